// File: rtl/pet_bank_decoder.sv
// pet_bank_decoder
//   Registered PET memory-map decoder with 8096-style 64 KB expansion banking.
//   The address is sampled on strobe_i. Chip selects and the translated
//   physical RAM address appear one clock later, qualified by valid_o.
//
// Ports
//   clk_i, reset_i      clock and synchronous active-high reset
//   strobe_i            one-cycle request; addr_i, rw_b_i and data_i are valid
//   addr_i              bus address; bit 16 set selects host direct access
//   rw_b_i              1 = read, 0 = write
//   data_i              write data, used only by the control register at $FFF0
//   valid_o             one-cycle pulse, decode outputs valid
//   ram_en_o            RAM array selected (RAM, VRAM, ROM, expansion, host)
//   ram_addr_o          physical RAM address
//   is_mirrored_o       VRAM region
//   is_readonly_o       write-protected region
//   wr_inhibit_o        write to a write-protected region; suppress the RAM write
//   magic_en_o          $E800-$E80F
//   io_en_o             any $E810-$E8FF access
//   io_sel_o            one-hot device select (PIA1, PIA2, VIA, CRTC)
//   ctrl_o              current expansion control register
//   ctrl_wr_o           pulse: control register written
module pet_bank_decoder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int IO_CHANNELS = 4,
  parameter int EXP_EN      = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   strobe_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic                   rw_b_i,
  input  logic [7:0]             data_i,
  output logic                   valid_o,
  output logic                   ram_en_o,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic                   is_mirrored_o,
  output logic                   is_readonly_o,
  output logic                   wr_inhibit_o,
  output logic                   magic_en_o,
  output logic                   io_en_o,
  output logic [IO_CHANNELS-1:0] io_sel_o,
  output logic [7:0]             ctrl_o,
  output logic                   ctrl_wr_o
);

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(17'h0FFF0);

  logic [15:0]           a;
  logic                  host;
  logic                  in_low;
  logic                  in_vram;
  logic                  in_magic;
  logic                  in_io;
  logic                  in_peek_io;
  logic                  exp_hit;
  logic [1:0]            bank;
  logic [1:0]            io_ch;
  logic                  ctrl_hit;

  logic                  ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic                  mirr_d;
  logic                  ro_d;
  logic                  magic_d;
  logic                  io_d;
  logic [IO_CHANNELS-1:0] io_sel_d;

  logic                  vld_p0;
  logic                  ram_en_p0;
  logic [ADDR_WIDTH-1:0] ram_addr_p0;
  logic                  mirr_p0;
  logic                  ro_p0;
  logic                  wr_inh_p0;
  logic                  magic_p0;
  logic                  io_p0;
  logic [IO_CHANNELS-1:0] io_sel_p0;
  logic [7:0]            ctrl_p0;
  logic                  ctrl_wr_p0;

  assign a    = addr_i[15:0];
  assign host = addr_i[16];

  // Region predicates on the 16-bit CPU address.
  assign in_low     = ~a[15];
  assign in_vram    = (a[15:12] == 4'h8);
  assign in_magic   = (a[15:4] == 12'hE80);
  assign in_io      = (a[15:8] == 8'hE8) && !in_magic;
  assign in_peek_io = (a[15:11] == 5'b11101);   // $E800-$EFFF

  // Banked window covers the whole upper 32 KB except the peek-through holes.
  assign exp_hit = (EXP_EN != 0) && ctrl_p0[7] && !host && a[15]
                   && !(ctrl_p0[5] && in_vram)
                   && !(ctrl_p0[6] && in_peek_io);

  assign bank = a[14] ? {ctrl_p0[3], 1'b1} : {ctrl_p0[2], 1'b0};

  // Device number is the highest set bit of A[7:4]; in_io guarantees one is set.
  assign io_ch = a[7] ? 2'd3 : a[6] ? 2'd2 : a[5] ? 2'd1 : 2'd0;

  assign ctrl_hit = (EXP_EN != 0) && !rw_b_i && (addr_i == CTRL_ADDR);

  always_comb begin
    ram_en_d   = 1'b0;
    ram_addr_d = addr_i;
    mirr_d     = 1'b0;
    ro_d       = 1'b0;
    magic_d    = 1'b0;
    io_d       = 1'b0;
    io_sel_d   = '0;
    if (host) begin
      ram_en_d = 1'b1;
    end else if (exp_hit) begin
      ram_en_d   = 1'b1;
      ram_addr_d = ADDR_WIDTH'({1'b1, bank, a[13:0]});
      ro_d       = a[14] ? ctrl_p0[1] : ctrl_p0[0];
    end else if (in_low) begin
      ram_en_d = 1'b1;
    end else if (in_vram) begin
      ram_en_d = 1'b1;
      mirr_d   = 1'b1;
    end else if (in_magic) begin
      magic_d = 1'b1;
    end else if (in_io) begin
      io_d = 1'b1;
      // Channels beyond IO_CHANNELS have no select bit and stay deselected.
      for (int i = 0; i < IO_CHANNELS; i++) begin
        if (io_ch == 2'(i)) io_sel_d[i] = 1'b1;
      end
    end else begin
      ram_en_d = 1'b1;
      ro_d     = 1'b1;
    end
  end

  // Stage p0: decode registers; the ctrl write takes effect after this decode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p0      <= 1'b0;
      ctrl_wr_p0  <= 1'b0;
      ctrl_p0     <= 8'h00;
      ram_en_p0   <= 1'b0;
      ram_addr_p0 <= '0;
      mirr_p0     <= 1'b0;
      ro_p0       <= 1'b0;
      wr_inh_p0   <= 1'b0;
      magic_p0    <= 1'b0;
      io_p0       <= 1'b0;
      io_sel_p0   <= '0;
    end else begin
      vld_p0     <= strobe_i;
      ctrl_wr_p0 <= strobe_i && ctrl_hit;
      if (strobe_i) begin
        ram_en_p0   <= ram_en_d;
        ram_addr_p0 <= ram_addr_d;
        mirr_p0     <= mirr_d;
        ro_p0       <= ro_d;
        wr_inh_p0   <= !rw_b_i && ro_d;
        magic_p0    <= magic_d;
        io_p0       <= io_d;
        io_sel_p0   <= io_sel_d;
        if (ctrl_hit) ctrl_p0 <= data_i;
      end
    end
  end

  assign valid_o       = vld_p0;
  assign ram_en_o      = ram_en_p0;
  assign ram_addr_o    = ram_addr_p0;
  assign is_mirrored_o = mirr_p0;
  assign is_readonly_o = ro_p0;
  assign wr_inhibit_o  = wr_inh_p0;
  assign magic_en_o    = magic_p0;
  assign io_en_o       = io_p0;
  assign io_sel_o      = io_sel_p0;
  assign ctrl_o        = ctrl_p0;
  assign ctrl_wr_o     = ctrl_wr_p0;

endmodule

// File: tb/tb_pet_bank_decoder.sv
// Testbench for pet_bank_decoder: three instances (4 I/O channels with
// expansion, 2 I/O channels with expansion, 4 I/O channels without expansion)
// share one stimulus stream and are compared against a behavioural model.
module tb_pet_bank_decoder;

  localparam int AW = 17;

  typedef struct packed {
    logic          valid;
    logic          ram_en;
    logic          mirr;
    logic          ro;
    logic          wrinh;
    logic          magic;
    logic          io;
    logic          ctrl_wr;
    logic [16:0]   addr;
    logic [3:0]    sel;
    logic [7:0]    ctrl;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          strobe = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          rw_b = 1'b1;
  logic [7:0]    data = 8'h00;

  logic          valid_a, ram_en_a, mirr_a, ro_a, wrinh_a, magic_a, io_a, ctrl_wr_a;
  logic [AW-1:0] ram_addr_a;
  logic [3:0]    sel_a;
  logic [7:0]    ctrl_a;
  logic          valid_b, ram_en_b, mirr_b, ro_b, wrinh_b, magic_b, io_b, ctrl_wr_b;
  logic [AW-1:0] ram_addr_b;
  logic [1:0]    sel_b;
  logic [7:0]    ctrl_b;
  logic          valid_c, ram_en_c, mirr_c, ro_c, wrinh_c, magic_c, io_c, ctrl_wr_c;
  logic [AW-1:0] ram_addr_c;
  logic [3:0]    sel_c;
  logic [7:0]    ctrl_c;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   run    = 1'b0;
  exp_t ea, eb, ec;
  logic [7:0] mctrl;

  always #5 clk = ~clk;

  pet_bank_decoder #(.ADDR_WIDTH(AW), .IO_CHANNELS(4), .EXP_EN(1)) u_a (
    .clk_i(clk), .reset_i(reset), .strobe_i(strobe), .addr_i(addr), .rw_b_i(rw_b),
    .data_i(data), .valid_o(valid_a), .ram_en_o(ram_en_a), .ram_addr_o(ram_addr_a),
    .is_mirrored_o(mirr_a), .is_readonly_o(ro_a), .wr_inhibit_o(wrinh_a),
    .magic_en_o(magic_a), .io_en_o(io_a), .io_sel_o(sel_a), .ctrl_o(ctrl_a),
    .ctrl_wr_o(ctrl_wr_a));

  pet_bank_decoder #(.ADDR_WIDTH(AW), .IO_CHANNELS(2), .EXP_EN(1)) u_b (
    .clk_i(clk), .reset_i(reset), .strobe_i(strobe), .addr_i(addr), .rw_b_i(rw_b),
    .data_i(data), .valid_o(valid_b), .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b),
    .is_mirrored_o(mirr_b), .is_readonly_o(ro_b), .wr_inhibit_o(wrinh_b),
    .magic_en_o(magic_b), .io_en_o(io_b), .io_sel_o(sel_b), .ctrl_o(ctrl_b),
    .ctrl_wr_o(ctrl_wr_b));

  pet_bank_decoder #(.ADDR_WIDTH(AW), .IO_CHANNELS(4), .EXP_EN(0)) u_c (
    .clk_i(clk), .reset_i(reset), .strobe_i(strobe), .addr_i(addr), .rw_b_i(rw_b),
    .data_i(data), .valid_o(valid_c), .ram_en_o(ram_en_c), .ram_addr_o(ram_addr_c),
    .is_mirrored_o(mirr_c), .is_readonly_o(ro_c), .wr_inhibit_o(wrinh_c),
    .magic_en_o(magic_c), .io_en_o(io_c), .io_sel_o(sel_c), .ctrl_o(ctrl_c),
    .ctrl_wr_o(ctrl_wr_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-map rules as address ranges; ctrl is the value before this access.
  function automatic exp_t model(input logic [16:0] a, input logic rw, input logic [7:0] c,
                                 input int ioch, input bit exp_en);
    exp_t e;
    int   aa;
    int   bank;
    int   n;
    bit   xp;
    e       = '0;
    e.valid = 1'b1;
    e.addr  = a;
    aa      = int'(a[15:0]);
    if (a[16]) begin
      e.ram_en = 1'b1;
    end else begin
      xp = exp_en && c[7] && aa >= 'h8000
           && !(c[5] && aa < 'h9000)
           && !(c[6] && aa >= 'hE800 && aa < 'hF000);
      if (xp) begin
        if (aa >= 'hC000) begin
          bank = 1 + 2 * int'(c[3]);
          e.ro = c[1];
        end else begin
          bank = 2 * int'(c[2]);
          e.ro = c[0];
        end
        e.addr   = 17'('h10000 + bank * 'h4000 + aa % 'h4000);
        e.ram_en = 1'b1;
      end else if (aa < 'h8000) begin
        e.ram_en = 1'b1;
      end else if (aa < 'h9000) begin
        e.ram_en = 1'b1;
        e.mirr   = 1'b1;
      end else if (aa >= 'hE800 && aa < 'hE810) begin
        e.magic = 1'b1;
      end else if (aa >= 'hE810 && aa < 'hE900) begin
        e.io = 1'b1;
        n = (aa % 256) / 16;
        n = (n >= 8) ? 3 : (n >= 4) ? 2 : (n >= 2) ? 1 : 0;
        if (n < ioch) e.sel = 4'(1 << n);
      end else begin
        e.ram_en = 1'b1;
        e.ro     = 1'b1;
      end
    end
    e.wrinh   = e.ro && !rw;
    e.ctrl_wr = exp_en && !rw && (a == 17'h0FFF0);
    return e;
  endfunction

  // Drive one clock worth of inputs and advance the model past that edge.
  task automatic step(input bit stb, input logic [16:0] ad, input bit rw,
                      input logic [7:0] d, input bit rst);
    strobe = stb;
    addr   = ad;
    rw_b   = rw;
    data   = d;
    reset  = rst;
    @(posedge clk);
    if (rst) begin
      ea = '0; eb = '0; ec = '0; mctrl = 8'h00;
    end else begin
      ea.valid = 1'b0; ea.ctrl_wr = 1'b0;
      eb.valid = 1'b0; eb.ctrl_wr = 1'b0;
      ec.valid = 1'b0; ec.ctrl_wr = 1'b0;
      if (stb) begin
        ea = model(ad, rw, mctrl, 4, 1'b1);
        eb = model(ad, rw, mctrl, 2, 1'b1);
        ec = model(ad, rw, 8'h00, 4, 1'b0);
        if (ea.ctrl_wr) mctrl = d;
      end
    end
    ea.ctrl = mctrl;
    eb.ctrl = mctrl;
    ec.ctrl = 8'h00;
    #1;
    strobe = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic rd(input logic [16:0] ad);
    step(1'b1, ad, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [16:0] ad, input logic [7:0] d);
    step(1'b1, ad, 1'b0, d, 1'b0);
  endtask

  task automatic cmp(input string tag, input exp_t g, input exp_t e);
    chk({tag, " valid"},   32'(g.valid),   32'(e.valid));
    chk({tag, " ram_en"},  32'(g.ram_en),  32'(e.ram_en));
    chk({tag, " mirr"},    32'(g.mirr),    32'(e.mirr));
    chk({tag, " ro"},      32'(g.ro),      32'(e.ro));
    chk({tag, " wrinh"},   32'(g.wrinh),   32'(e.wrinh));
    chk({tag, " magic"},   32'(g.magic),   32'(e.magic));
    chk({tag, " io"},      32'(g.io),      32'(e.io));
    chk({tag, " ctrl_wr"}, 32'(g.ctrl_wr), 32'(e.ctrl_wr));
    chk({tag, " addr"},    32'(g.addr),    32'(e.addr));
    chk({tag, " sel"},     32'(g.sel),     32'(e.sel));
    chk({tag, " ctrl"},    32'(g.ctrl),    32'(e.ctrl));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      cmp("a", {valid_a, ram_en_a, mirr_a, ro_a, wrinh_a, magic_a, io_a, ctrl_wr_a,
                ram_addr_a, sel_a, ctrl_a}, ea);
      cmp("b", {valid_b, ram_en_b, mirr_b, ro_b, wrinh_b, magic_b, io_b, ctrl_wr_b,
                ram_addr_b, 2'b00, sel_b, ctrl_b}, eb);
      cmp("c", {valid_c, ram_en_c, mirr_c, ro_c, wrinh_c, magic_c, io_c, ctrl_wr_c,
                ram_addr_c, sel_c, ctrl_c}, ec);
    end
  end

  initial begin
    ea = '0; eb = '0; ec = '0; mctrl = 8'h00;
    step(1'b0, '0, 1'b1, 8'h00, 1'b1);
    run = 1'b1;
    step(1'b0, '0, 1'b1, 8'h00, 1'b0);
    chk("rst valid", 32'(valid_a), 32'h0);
    chk("rst ctrl", 32'(ctrl_a), 32'h00);
    chk("rst ram_en", 32'(ram_en_a), 32'h0);

    rd(17'h01234);
    chk("rd1234 valid", 32'(valid_a), 32'h1);
    chk("rd1234 ram_en", 32'(ram_en_a), 32'h1);
    chk("rd1234 addr", 32'(ram_addr_a), 32'h01234);
    chk("rd1234 ro", 32'(ro_a), 32'h0);
    step(1'b0, '0, 1'b1, 8'h00, 1'b0);
    chk("idle valid", 32'(valid_a), 32'h0);
    chk("idle hold addr", 32'(ram_addr_a), 32'h01234);
    rd(17'h08400);
    chk("rd8400 mirr", 32'(mirr_a), 32'h1);

    rd(17'h0E805); chk("E805 magic", 32'(magic_a), 32'h1);
    rd(17'h0E812); chk("E812 sel", 32'(sel_a), 32'h1);
    rd(17'h0E830); chk("E830 sel", 32'(sel_a), 32'h2);
    rd(17'h0E850); chk("E850 sel", 32'(sel_a), 32'h4);
    chk("E850 io2", 32'(io_b), 32'h1);
    chk("E850 sel2", 32'(sel_b), 32'h0);
    rd(17'h0E8C0); chk("E8C0 sel", 32'(sel_a), 32'h8);

    wr(17'h0C000, 8'h00);
    chk("wrC000 ro", 32'(ro_a), 32'h1);
    chk("wrC000 wrinh", 32'(wrinh_a), 32'h1);
    wr(17'h0FFF0, 8'h86);
    chk("wrFFF0 ctrl_wr", 32'(ctrl_wr_a), 32'h1);
    chk("wrFFF0 ctrl", 32'(ctrl_a), 32'h86);
    chk("wrFFF0 rom", 32'(ro_a), 32'h1);
    chk("wrFFF0 addr", 32'(ram_addr_a), 32'h0FFF0);
    chk("noexp ctrl", 32'(ctrl_c), 32'h00);
    chk("noexp ctrl_wr", 32'(ctrl_wr_c), 32'h0);

    wr(17'h0FFF0, 8'h8C);
    rd(17'h09000); chk("bank2 addr", 32'(ram_addr_a), 32'h19000);
    rd(17'h0C123); chk("bank3 addr", 32'(ram_addr_a), 32'h1C123);
    wr(17'h0FFF0, 8'h8D);
    wr(17'h0A000, 8'h11);
    chk("wrA000 wrinh", 32'(wrinh_a), 32'h1);
    chk("wrA000 addr", 32'(ram_addr_a), 32'h1A000);

    wr(17'h0FFF0, 8'hE0);
    rd(17'h08010);
    chk("peek vram mirr", 32'(mirr_a), 32'h1);
    chk("peek vram addr", 32'(ram_addr_a), 32'h08010);
    rd(17'h0E840); chk("peek io sel", 32'(sel_a), 32'h4);
    rd(17'h0E900);
    chk("peek rom ro", 32'(ro_a), 32'h1);
    chk("peek rom addr", 32'(ram_addr_a), 32'h0E900);

    wr(17'h0FFF0, 8'h80);
    rd(17'h08010);
    chk("exp8010 addr", 32'(ram_addr_a), 32'h10010);
    chk("exp8010 mirr", 32'(mirr_a), 32'h0);
    rd(17'h0E840);
    chk("expE840 addr", 32'(ram_addr_a), 32'h16840);
    chk("expE840 ro", 32'(ro_a), 32'h0);
    chk("expE840 io", 32'(io_a), 32'h0);

    // Back-to-back strobes: each read sees the write just before it.
    for (int i = 0; i < 3; i++) begin
      strobe = 1'b1;
      wr(17'h0FFF0, 8'h80);
      strobe = 1'b1;
      rd(17'h0C000);
      chk("b2b bank1 addr", 32'(ram_addr_a), 32'h14000);
      chk("b2b bank1 ro", 32'(ro_a), 32'h0);
      wr(17'h0FFF0, 8'h00);
      rd(17'h0C000);
      chk("b2b rom addr", 32'(ram_addr_a), 32'h0C000);
      chk("b2b rom ro", 32'(ro_a), 32'h1);
    end

    wr(17'h0FFF0, 8'h8C);
    step(1'b1, 17'h0FFF0, 1'b0, 8'hFF, 1'b1);
    chk("rst+stb valid", 32'(valid_a), 32'h0);
    chk("rst+stb ctrl", 32'(ctrl_a), 32'h00);
    chk("rst+stb ctrl_wr", 32'(ctrl_wr_a), 32'h0);

    wr(17'h0FFF0, 8'h83);
    wr(17'h1FFF0, 8'h55);
    chk("host ram_en", 32'(ram_en_a), 32'h1);
    chk("host ro", 32'(ro_a), 32'h0);
    chk("host addr", 32'(ram_addr_a), 32'h1FFF0);
    chk("host ctrl kept", 32'(ctrl_a), 32'h83);
    chk("host ctrl_wr", 32'(ctrl_wr_a), 32'h0);

    // Randomized traffic biased toward the interesting regions.
    for (int i = 0; i < 800; i++) begin
      logic [16:0] ra;
      int          sel;
      bit          rrw;
      sel = int'($urandom_range(0, 9));
      rrw = 1'($urandom_range(0, 1));
      case (sel)
        0:       begin ra = 17'h0FFF0; rrw = 1'b0; end
        1:       ra = 17'h10000 | 17'($urandom_range(0, 'hFFFF));
        2:       ra = 17'($urandom_range('h8000, 'h8FFF));
        3:       ra = 17'($urandom_range('hE800, 'hE8FF));
        4:       ra = 17'($urandom_range('hE900, 'hEFFF));
        5:       ra = 17'($urandom_range('hC000, 'hFFFF));
        default: ra = 17'($urandom_range(0, 'hFFFF));
      endcase
      step($urandom_range(0, 9) < 8, ra, rrw, 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) == 0);
    end

    step(1'b0, '0, 1'b1, 8'h00, 1'b0);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
